// File: rtl/mem_pkg.sv
// Shared encodings and op decode for the memory-access stage.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unlisted encodings fall out as neither load nor store, i.e. NONE.
  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic size_e op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_B;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_H;
      default:                 return SZ_W;
    endcase
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of the load word and extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane select is little-endian: lane 0 is rdata[7:0].
  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext     = (op_i == MEM_LB) || (op_i == MEM_LH);
    case (op_size(op_i))
      SZ_B:    data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{sext & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over req/ack, stalls EX while
// an access is in flight, and registers the write-back triple.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_alu_result,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_store_data,
  input  logic        flush,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        misalign_exc,
  output logic        buserr_exc
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic        ex_ld, ex_st;
  size_e       ex_sz;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  load_align u_align (
    .op_i    (op_q),
    .addr_i  (lane_q),
    .rdata_i (dmem_rdata),
    .data_o  (ld_data)
  );

  // Store lane encoding: narrow data is replicated so any lane sees it.
  always_comb begin
    ex_ld = is_load(ex_mem_op);
    ex_st = is_store(ex_mem_op);
    ex_sz = op_size(ex_mem_op);
    case (ex_sz)
      SZ_B: begin
        st_be    = 4'b0001 << ex_alu_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      SZ_H: begin
        st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data;
      end
    endcase
  end

  // Next-state: accept in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    waddr_d    = waddr_q;
    we_d       = we_q;
    lane_d     = lane_q;
    req_d      = req_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && !flush) begin
          if (!ex_ld && !ex_st) begin
            wb_we_d    = ex_we && (ex_waddr != 5'd0);
            wb_waddr_d = ex_waddr;
            wb_wdata_d = ex_alu_result;
          end else if (misaligned(ex_sz, ex_alu_result[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 8'd0;
            op_d    = ex_mem_op;
            waddr_d = ex_waddr;
            we_d    = ex_we;
            lane_d  = ex_alu_result[1:0];
            req_d   = 1'b1;
            wr_d    = ex_st;
            addr_d  = ex_alu_result;
            be_d    = ex_st ? st_be : 4'b1111;
            wdata_d = ex_st ? st_wdata : 32'd0;
          end
        end
      end
      ST_ACCESS: begin
        // Ack beats timeout when both land in the last counted cycle.
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (is_load(op_q)) begin
            wb_we_d    = we_q && (waddr_q != 5'd0);
            wb_waddr_d = waddr_q;
            wb_wdata_d = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset_n high holds the block in reset.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      op_q       <= 4'd0;
      waddr_q    <= 5'd0;
      we_q       <= 1'b0;
      lane_q     <= 2'd0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wdata_q <= 32'd0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      lane_q     <= lane_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign stall_req    = (state_q == ST_ACCESS);
  assign dmem_req     = req_q;
  assign dmem_wr      = wr_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_we        = wb_we_q;
  assign wb_waddr     = wb_waddr_q;
  assign wb_wdata     = wb_wdata_q;
  assign misalign_exc = mis_q;
  assign buserr_exc   = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus random bench for mem_stage against an arithmetic reference.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_we, flush;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic        stall_req, dmem_req, dmem_wr, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_we, misalign_exc, buserr_exc;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int errors = 0;
  int checks = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_alu_result(ex_alu_result), .ex_mem_op(ex_mem_op),
    .ex_store_data(ex_store_data), .flush(flush),
    .stall_req(stall_req), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .misalign_exc(misalign_exc), .buserr_exc(buserr_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction

  function automatic bit m_store(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction

  function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return a % 2 != 0;
    if (op == 4'd5 || op == 4'd8) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_ldval(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] r);
    logic [31:0] v;
    case (op)
      4'd1, 4'd2: begin
        v = (r >> (8 * (a % 4))) & 32'hFF;
        if (op == 4'd1 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      4'd3, 4'd4: begin
        v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (op == 4'd3 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd6) return 4'(1 << (a % 4));
    if (op == 4'd7) return ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] d);
    if (op == 4'd6) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 4'd7) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction through the stage; dly = ACCESS cycle carrying the ack
  // (0 means never acked). Called and returns at posedge+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input logic we, input logic [4:0] wa,
                        input int dly, input bit fl_acc);
    bit ld, st, done;
    ld = m_load(op);
    st = m_store(op);
    ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = a; ex_store_data = sd;
    ex_we = we; ex_waddr = wa; flush = 1'b0;
    chk("stall_before", stall_req, 1'b0);
    tick();
    if (!ld && !st) begin
      chk("alu_wb_we", wb_we, we && wa != 0);
      chk("alu_wb_waddr", wb_waddr, wa);
      chk("alu_wb_wdata", wb_wdata, a);
      chk("alu_stall", stall_req, 1'b0);
      ex_valid = 1'b0;
      return;
    end
    if (m_misal(op, a)) begin
      chk("mis_exc", misalign_exc, 1'b1);
      chk("mis_req", dmem_req, 1'b0);
      chk("mis_stall", stall_req, 1'b0);
      chk("mis_wb_we", wb_we, 1'b0);
      ex_valid = 1'b0;
      tick();
      chk("mis_pulse_end", misalign_exc, 1'b0);
      return;
    end
    chk("acc_req", dmem_req, 1'b1);
    chk("acc_wr", dmem_wr, st);
    chk("acc_addr", dmem_addr, a);
    chk("acc_be", dmem_be, m_be(op, a));
    if (st) chk("acc_wdata", dmem_wdata, m_wd(op, sd));
    chk("acc_stall", stall_req, 1'b1);
    chk("acc_wb_we", wb_we, 1'b0);
    flush = fl_acc;
    done = 1'b0;
    for (int c = 1; c <= TO && !done; c++) begin
      if (c == dly) begin dmem_ack = 1'b1; dmem_rdata = rd; end
      tick();
      dmem_ack = 1'b0;
      if (c == dly) begin
        done = 1'b1;
        chk("cmp_req", dmem_req, 1'b0);
        chk("cmp_stall", stall_req, 1'b0);
        chk("cmp_buserr", buserr_exc, 1'b0);
        chk("cmp_wb_we", wb_we, ld && we && wa != 0);
        if (ld) begin
          chk("cmp_wb_waddr", wb_waddr, wa);
          chk("cmp_wb_wdata", wb_wdata, m_ldval(op, a, rd));
        end
      end else if (c == TO) begin
        done = 1'b1;
        chk("to_buserr", buserr_exc, 1'b1);
        chk("to_req", dmem_req, 1'b0);
        chk("to_stall", stall_req, 1'b0);
        chk("to_wb_we", wb_we, 1'b0);
        ex_valid = 1'b0; flush = 1'b0;
        tick();
        chk("to_pulse_end", buserr_exc, 1'b0);
      end else begin
        chk("hold_stall", stall_req, 1'b1);
        chk("hold_req", dmem_req, 1'b1);
        chk("hold_addr", dmem_addr, a);
        chk("hold_be", dmem_be, m_be(op, a));
      end
    end
    ex_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    ex_valid = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0; ex_alu_result = 32'd0;
    ex_mem_op = 4'd0; ex_store_data = 32'd0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();

    // Reset state
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_wr", dmem_wr, 1'b0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", dmem_be, 4'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_waddr", wb_waddr, 5'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_mis", misalign_exc, 1'b0);
    chk("rst_berr", buserr_exc, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    #3 reset_n = 1'b0;
    tick();

    // Directed cases
    run_op(4'd0, 32'h1234, 32'd0, 32'd0, 1'b1, 5'd5, 0, 1'b0);          // ALU pass
    run_op(4'd0, 32'hDEAD, 32'd0, 32'd0, 1'b1, 5'd0, 0, 1'b0);          // r0 write
    run_op(4'd1, 32'h103, 32'd0, 32'h80FF_0000, 1'b1, 5'd7, 3, 1'b0);   // LB
    chk("lb_value", wb_wdata, 32'hFFFF_FF80);
    run_op(4'd2, 32'h103, 32'd0, 32'h80FF_0000, 1'b1, 5'd7, 3, 1'b0);   // LBU
    chk("lbu_value", wb_wdata, 32'h0000_0080);
    run_op(4'd7, 32'h202, 32'h0000_ABCD, 32'd0, 1'b1, 5'd9, 1, 1'b0);   // SH upper
    run_op(4'd5, 32'h301, 32'd0, 32'd0, 1'b1, 5'd3, 1, 1'b0);           // misaligned LW
    run_op(4'd5, 32'h400, 32'd0, 32'd0, 1'b1, 5'd4, 0, 1'b0);           // timeout
    run_op(4'd5, 32'h400, 32'd0, 32'hCAFE_F00D, 1'b1, 5'd4, TO, 1'b0);  // ack in last cycle
    run_op(4'd3, 32'h502, 32'd0, 32'h9ABC_1234, 1'b1, 5'd6, 2, 1'b1);   // flush ignored

    // Flush in IDLE drops a memory op
    ex_valid = 1'b1; flush = 1'b1; ex_mem_op = 4'd5; ex_alu_result = 32'h600;
    ex_we = 1'b1; ex_waddr = 5'd8;
    tick();
    chk("flush_req", dmem_req, 1'b0);
    chk("flush_stall", stall_req, 1'b0);
    chk("flush_wb_we", wb_we, 1'b0);
    ex_valid = 1'b0; flush = 1'b0;

    // Reset mid-ACCESS
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_alu_result = 32'h700; ex_we = 1'b1; ex_waddr = 5'd2;
    tick();
    chk("pre_rst_req", dmem_req, 1'b1);
    tick();
    ex_valid = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_wb_we", wb_we, 1'b0);
    chk("mid_rst_stall", stall_req, 1'b0);
    #1 reset_n = 1'b0;
    tick();
    run_op(4'd0, 32'h0BAD_BEEF, 32'd0, 32'd0, 1'b1, 5'd11, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          d;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      if ($urandom_range(0, 7) == 0) begin
        ex_valid = 1'b1; flush = 1'b1; ex_mem_op = op; ex_alu_result = a;
        ex_we = 1'b1; ex_waddr = 5'd1;
        tick();
        chk("rnd_flush_wb_we", wb_we, 1'b0);
        chk("rnd_flush_req", dmem_req, 1'b0);
        ex_valid = 1'b0; flush = 1'b0;
      end
      run_op(op, a, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), d, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
